// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the sequential restoring divider:
//   - div_state_e : controller states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand/result width
//   - cnt_width() : width of the step counter, which must hold WIDTH itself
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Counter loads WIDTH and counts down to 1, so it needs $clog2(WIDTH+1) bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : div_pkg

// File: rtl/div_restore_step.sv
// div_restore_step
// One combinational restoring-division step.
// Ports:
//   r      : current partial remainder (always < d when d != 0)
//   q_msb  : next dividend bit shifted into the partial remainder
//   d      : divisor
//   r_next : partial remainder after the step
//   q_bit  : quotient bit produced by the step
module div_restore_step
#(
  parameter int WIDTH = 8
)
(
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             fits_s;

  // The trial value is T = {r, q_msb} - d, WIDTH+1 bits wide. When T is
  // non-negative it is below d, so its low WIDTH bits equal
  // {r[WIDTH-2:0], q_msb} - d taken modulo 2^WIDTH; only the sign decision
  // needs r's MSB. If r's MSB is set, {r, q_msb} >= 2^WIDTH > d and the
  // subtraction always succeeds.
  assign shifted_s = {r[WIDTH-2:0], q_msb};
  assign diff_s    = shifted_s - d;

  // Subtract-or-restore decision for this step.
  always_comb begin
    fits_s = 1'b0;
    if (r[WIDTH-1] == 1'b1) begin
      fits_s = 1'b1;
    end else if (shifted_s >= d) begin
      fits_s = 1'b1;
    end else begin
      fits_s = 1'b0;
    end
  end

  // Select the new partial remainder: difference if it fit, else restored value.
  always_comb begin
    r_next = shifted_s;
    q_bit  = 1'b0;
    if (fits_s) begin
      r_next = diff_s;
      q_bit  = 1'b1;
    end else begin
      r_next = shifted_s;
      q_bit  = 1'b0;
    end
  end

endmodule : div_restore_step

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   start       : request, sampled only while idle
//   dividend    : unsigned dividend, captured with start
//   divisor     : unsigned divisor, captured with start
//   busy        : high while a division is running or completing
//   done        : one-cycle pulse, results valid in that cycle
//   quotient    : registered quotient (all ones on divide-by-zero)
//   remainder   : registered remainder (dividend on divide-by-zero)
//   div_by_zero : registered flag for the last completed operation
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    count_r;

  logic [WIDTH-1:0] r_next_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] q_next_s;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_r),
    .q_msb  (q_r[WIDTH-1]),
    .d      (d_r),
    .r_next (r_next_s),
    .q_bit  (q_bit_s)
  );

  // Q doubles as the dividend shifter: its MSB feeds the step while the new
  // quotient bit enters at the LSB.
  assign q_next_s = {q_r[WIDTH-2:0], q_bit_s};

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      r_r         <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_r     <= {WIDTH{1'b0}};
            q_r     <= dividend;
            d_r     <= divisor;
            count_r <= CW'(WIDTH);
            busy    <= 1'b1;
            if (divisor == {WIDTH{1'b0}}) begin
              // Divide-by-zero skips the iteration entirely.
              state_r     <= ST_DONE;
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          r_r     <= r_next_s;
          q_r     <= q_next_s;
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            // Final step: publish the results straight from the step outputs.
            state_r     <= ST_DONE;
            quotient    <= q_next_s;
            remainder   <= r_next_s;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end else begin
            done <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
// Directed checks of the restoring divider at WIDTH=8 plus a short random
// sweep against a / and % reference.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  int first_done = 0;
  int pulses = 0;
  int done_at = 0;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] seen_q;
  logic [W-1:0] seen_r;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait (bounded) for done, check latency, busy span,
  // results, then step into the first IDLE cycle and check hold behaviour.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int lat;
    int busy_cnt;
    int exp_lat;
    exp_lat = (b == 8'd0) ? 1 : W + 1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    if (busy === 1'b1) busy_cnt++;
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " busy_span"}, busy_cnt, exp_lat);
    check_eq({tag, " quotient"}, quotient, eq);
    check_eq({tag, " remainder"}, remainder, er);
    check_eq({tag, " dbz"}, div_by_zero, edz);
    last_done = cyc;
    tick();
    check_eq({tag, " done_low"}, done, 1'b0);
    check_eq({tag, " idle"}, busy, 1'b0);
    check_eq({tag, " hold_q"}, quotient, eq);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    tick();
    tick();
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst done", done, 1'b0);
    check_eq("rst quotient", quotient, 8'd0);
    check_eq("rst remainder", remainder, 8'd0);
    check_eq("rst dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    tick();

    run_op("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);

    // Back-to-back: second start in the first IDLE cycle.
    run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    first_done = last_done;
    run_op("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    check_eq("b2b spacing", last_done - first_done, 10);

    run_op("13/0", 8'd13, 8'd0, 8'd255, 8'd13, 1'b1);
    run_op("100/10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0);

    // start pulses during RUN must be ignored.
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    tick();
    pulses = 0;
    done_at = 0;
    seen_q = 8'd0;
    seen_r = 8'd0;
    for (int i = 1; i <= 14; i++) begin
      start = (i >= 2 && i <= 5) ? 1'b1 : 1'b0;
      dividend = 8'd50;
      divisor = 8'd5;
      if (done === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          done_at = i;
          seen_q = quotient;
          seen_r = remainder;
        end
      end
      tick();
    end
    start = 1'b0;
    check_eq("ignore pulses", pulses, 1);
    check_eq("ignore latency", done_at, 9);
    check_eq("ignore quotient", seen_q, 8'd28);
    check_eq("ignore remainder", seen_r, 8'd4);

    // Reset in the middle of an operation.
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst busy", busy, 1'b0);
    check_eq("midrst done", done, 1'b0);
    check_eq("midrst quotient", quotient, 8'd0);
    check_eq("midrst remainder", remainder, 8'd0);
    check_eq("midrst dbz", div_by_zero, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    check_eq("midrst no_done", pulses, 0);
    run_op("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

    // Boundary operands.
    run_op("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run_op("254/255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0);
    run_op("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    run_op("128/2", 8'd128, 8'd2, 8'd64, 8'd0, 1'b0);
    run_op("255/16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
    run_op("0/0", 8'd0, 8'd0, 8'd255, 8'd0, 1'b1);

    // Random sweep against the / and % reference.
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = (i % 10 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      if (rb == 8'd0) begin
        run_op($sformatf("rnd%0d %0d/%0d", i, ra, rb), ra, rb, 8'd255, ra, 1'b1);
      end else begin
        run_op($sformatf("rnd%0d %0d/%0d", i, ra, rb), ra, rb, ra / rb, ra % rb, 1'b0);
        check_eq($sformatf("rnd%0d identity", i),
                 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_restoring_divider
